// File: rtl/hline_pkg.sv
// -----------------------------------------------------------------------------
// hline_pkg
// Shared definitions for the hline z-buffer engines and the AXI burst
// arbiter: arbiter state encoding, AXI address width and the longest
// burst the master supports.
// Ports: none (package).
// -----------------------------------------------------------------------------
package hline_pkg;

    localparam int ADDR_W        = 32;
    localparam int AXI_MAX_BURST = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/hline_axi_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Scans i_req starting at i_ptr
// and wrapping modulo NREQ; the first set bit wins.
// Ports:
//   i_req   [NREQ]   request vector
//   i_ptr   [IDX_W]  index that has highest priority (always < NREQ)
//   o_gnt   [NREQ]   one-hot winner (all zero when no request)
//   o_idx   [IDX_W]  winner index
//   o_valid          at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Walk the priority order from lowest to highest so the highest-priority
    // set bit is the last one written. The wrap is done with a compare and
    // subtract so NREQ need not be a power of two.
    always_comb begin
        int unsigned w_pos;
        o_idx   = '0;
        o_gnt   = '0;
        o_valid = |i_req;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= NREQ) begin
                w_pos = w_pos - NREQ;
            end
            if (i_req[w_pos]) begin
                o_idx = IDX_W'(w_pos);
            end
        end
        o_gnt[o_idx] = o_valid;
    end

endmodule

// File: rtl/hline_axi_arb.sv
// -----------------------------------------------------------------------------
// hline_axi_arb
// Round-robin arbiter/sequencer sharing one AXI burst master between NREQ
// burst requesters. One request is granted at a time; its command is latched,
// issued to the master and ownership is held until the master reports done.
// A watchdog aborts bursts that never complete.
// Ports:
//   clk, nreset        clock, asynchronous active-low reset
//   req/req_rnw        per-requester request and direction (1 = read)
//   req_addr/req_len   packed per-requester start address / length in words
//   gnt                one-hot ownership, grant until done
//   req_done           one-cycle completion pulse to the owner
//   m_go/m_ready       command handshake to the burst master
//   m_rnw/m_addr/m_len latched command
//   axi_done           burst-complete pulse from the master
//   owner              index of current or last owner
//   busy               arbiter not idle
//   timeout_err/clr_err sticky watchdog flag and its synchronous clear
// -----------------------------------------------------------------------------
module hline_axi_arb
    import hline_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int LEN_W   = 9,
    parameter int TIMEOUT = 4095
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_rnw,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*LEN_W-1:0]    req_len,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          req_done,
    output logic                     m_go,
    input  logic                     m_ready,
    output logic                     m_rnw,
    output logic [ADDR_W-1:0]        m_addr,
    output logic [LEN_W-1:0]         m_len,
    input  logic                     axi_done,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     busy,
    output logic                     timeout_err,
    input  logic                     clr_err
);

    localparam int IDX_W       = $clog2(NREQ);
    localparam int WD_W        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int WD_LAST_INT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    arb_state_t         r_state;
    arb_state_t         w_nextState;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic [NREQ-1:0]    r_gnt;
    logic [NREQ-1:0]    r_reqDone;
    logic               r_mGo;
    logic               r_mRnw;
    logic [ADDR_W-1:0]  r_mAddr;
    logic [LEN_W-1:0]   r_mLen;
    logic [WD_W-1:0]    r_wdCnt;
    logic               r_timeoutErr;

    logic [NREQ-1:0]    w_pickGnt;
    logic [IDX_W-1:0]   w_pickIdx;
    logic               w_pickValid;
    logic [ADDR_W-1:0]  w_selAddr;
    logic [LEN_W-1:0]   w_selLen;
    logic               w_selRnw;
    logic               w_wdAbort;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_pickGnt),
        .o_idx   (w_pickIdx),
        .o_valid (w_pickValid)
    );

    assign w_selAddr = req_addr[int'(w_pickIdx)*ADDR_W +: ADDR_W];
    assign w_selLen  = req_len[int'(w_pickIdx)*LEN_W +: LEN_W];
    assign w_selRnw  = req_rnw[w_pickIdx];

    // The abort fires on the TIMEOUT-th WAIT cycle; an axi_done on that same
    // cycle wins and the burst completes normally.
    assign w_wdAbort = (TIMEOUT != 0) && (r_state == WAIT) && !axi_done &&
                       (r_wdCnt == WD_W'(WD_LAST_INT));

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_pickValid) w_nextState = (w_selLen == '0) ? DONE : ISSUE;
            ISSUE:   if (m_ready) w_nextState = WAIT;
            WAIT:    if (axi_done || w_wdAbort) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Command latch, grant/done bookkeeping, watchdog and error flag.
    // Zero-length grants still latch the command but never raise m_go.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_owner      <= '0;
            r_gnt        <= '0;
            r_reqDone    <= '0;
            r_mGo        <= 1'b0;
            r_mRnw       <= 1'b0;
            r_mAddr      <= '0;
            r_mLen       <= '0;
            r_wdCnt      <= '0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_reqDone <= '0;
            case (r_state)
                IDLE: begin
                    if (w_pickValid) begin
                        r_gnt   <= w_pickGnt;
                        r_owner <= w_pickIdx;
                        r_mRnw  <= w_selRnw;
                        r_mAddr <= w_selAddr;
                        r_mLen  <= w_selLen;
                        r_mGo   <= (w_selLen != '0);
                    end
                end
                ISSUE: begin
                    if (m_ready) begin
                        r_mGo <= 1'b0;
                    end
                end
                DONE: begin
                    r_reqDone <= r_gnt;
                    r_gnt     <= '0;
                    r_ptr     <= (r_owner == IDX_W'(NREQ - 1)) ? '0 : r_owner + 1'b1;
                end
                default: begin
                end
            endcase

            if (r_state != WAIT) begin
                r_wdCnt <= '0;
            end else if (r_wdCnt != '1) begin
                r_wdCnt <= r_wdCnt + 1'b1;
            end

            if (w_wdAbort) begin
                r_timeoutErr <= 1'b1;
            end else if (clr_err) begin
                r_timeoutErr <= 1'b0;
            end
        end
    end

    assign gnt         = r_gnt;
    assign req_done    = r_reqDone;
    assign m_go        = r_mGo;
    assign m_rnw       = r_mRnw;
    assign m_addr      = r_mAddr;
    assign m_len       = r_mLen;
    assign owner       = r_owner;
    assign busy        = (r_state != IDLE);
    assign timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_hline_axi_arb.sv
// -----------------------------------------------------------------------------
// tb_hline_axi_arb
// Self-checking bench for hline_axi_arb. A small round-robin model (pointer
// plus "first set bit from pointer" rule) predicts each winner; per-burst
// timing expectations come from the grant/issue/wait/done sequence.
// -----------------------------------------------------------------------------
module tb_hline_axi_arb;

    localparam int NREQ    = 4;
    localparam int LEN_W   = 9;
    localparam int TIMEOUT = 16;

    logic                    clk;
    logic                    nreset;
    logic [NREQ-1:0]         req;
    logic [NREQ-1:0]         req_rnw;
    logic [NREQ*32-1:0]      req_addr;
    logic [NREQ*LEN_W-1:0]   req_len;
    logic [NREQ-1:0]         gnt;
    logic [NREQ-1:0]         req_done;
    logic                    m_go;
    logic                    m_ready;
    logic                    m_rnw;
    logic [31:0]             m_addr;
    logic [LEN_W-1:0]        m_len;
    logic                    axi_done;
    logic [1:0]              owner;
    logic                    busy;
    logic                    timeout_err;
    logic                    clr_err;

    logic [31:0]      addrArr [NREQ];
    logic [LEN_W-1:0] lenArr  [NREQ];

    int checks;
    int failures;
    int modelPtr;

    hline_axi_arb #(
        .NREQ    (NREQ),
        .LEN_W   (LEN_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .req         (req),
        .req_rnw     (req_rnw),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .gnt         (gnt),
        .req_done    (req_done),
        .m_go        (m_go),
        .m_ready     (m_ready),
        .m_rnw       (m_rnw),
        .m_addr      (m_addr),
        .m_len       (m_len),
        .axi_done    (axi_done),
        .owner       (owner),
        .busy        (busy),
        .timeout_err (timeout_err),
        .clr_err     (clr_err)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pack the per-requester arrays onto the flat buses.
    always_comb begin
        req_addr = '0;
        req_len  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*32 +: 32]      = addrArr[i];
            req_len[i*LEN_W +: LEN_W] = lenArr[i];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; everything is driven and sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first set bit scanning ptr, ptr+1, ... mod NREQ.
    function automatic int expectWinner(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Runs one arbitration from IDLE: present reqVec, then (for non-zero
    // length) hold m_ready low for readyDelay cycles, accept, wait doneDelay
    // cycles and pulse axi_done. Requester inputs are scrambled after the grant.
    task automatic applyStimulus(input logic [NREQ-1:0] reqVec, input int readyDelay,
                                 input int doneDelay, output int win);
        logic [31:0]      eAddr;
        logic [LEN_W-1:0] eLen;
        logic             eRnw;
        logic [63:0]      eGnt;
        win = expectWinner(reqVec, modelPtr);
        req = reqVec;
        tick();
        if (win < 0) begin
            checkOutput("idle_busy", 64'(busy), 64'd0);
            checkOutput("idle_gnt", 64'(gnt), 64'd0);
            return;
        end
        eAddr = addrArr[win];
        eLen  = lenArr[win];
        eRnw  = req_rnw[win];
        eGnt  = 64'(1) << win;
        checkOutput("grant_gnt", 64'(gnt), eGnt);
        checkOutput("grant_owner", 64'(owner), 64'(win));
        checkOutput("grant_busy", 64'(busy), 64'd1);
        checkOutput("grant_mgo", 64'(m_go), 64'(eLen != 0));

        req     = NREQ'($urandom);
        req_rnw = NREQ'($urandom);
        for (int i = 0; i < NREQ; i++) begin
            addrArr[i] = $urandom;
            lenArr[i]  = LEN_W'($urandom_range(0, 256));
        end

        if (eLen == 0) begin
            tick();
            checkOutput("zlen_done", 64'(req_done), eGnt);
            checkOutput("zlen_gnt", 64'(gnt), 64'd0);
            checkOutput("zlen_mgo", 64'(m_go), 64'd0);
            modelPtr = (win + 1) % NREQ;
            return;
        end

        checkOutput("grant_addr", 64'(m_addr), 64'(eAddr));
        checkOutput("grant_len", 64'(m_len), 64'(eLen));
        checkOutput("grant_rnw", 64'(m_rnw), 64'(eRnw));
        for (int c = 0; c < readyDelay; c++) begin
            tick();
            checkOutput("issue_hold_go", 64'(m_go), 64'd1);
            checkOutput("issue_hold_addr", 64'(m_addr), 64'(eAddr));
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checkOutput("accept_go", 64'(m_go), 64'd0);
        checkOutput("accept_gnt", 64'(gnt), eGnt);
        for (int c = 0; c < doneDelay; c++) begin
            tick();
        end
        checkOutput("wait_len", 64'(m_len), 64'(eLen));
        axi_done = 1'b1;
        tick();
        axi_done = 1'b0;
        checkOutput("done_gnt", 64'(gnt), eGnt);
        checkOutput("done_nopulse", 64'(req_done), 64'd0);
        tick();
        checkOutput("reqdone", 64'(req_done), eGnt);
        checkOutput("release_gnt", 64'(gnt), 64'd0);
        checkOutput("release_busy", 64'(busy), 64'd0);
        checkOutput("hold_addr", 64'(m_addr), 64'(eAddr));
        modelPtr = (win + 1) % NREQ;
    endtask

    initial begin
        int win;
        checks   = 0;
        failures = 0;
        modelPtr = 0;
        nreset   = 1'b0;
        req      = '0;
        req_rnw  = '0;
        m_ready  = 1'b0;
        axi_done = 1'b0;
        clr_err  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            addrArr[i] = '0;
            lenArr[i]  = '0;
        end
        #12;
        checkOutput("rst_gnt", 64'(gnt), 64'd0);
        checkOutput("rst_done", 64'(req_done), 64'd0);
        checkOutput("rst_mgo", 64'(m_go), 64'd0);
        checkOutput("rst_addr", 64'(m_addr), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_err", 64'(timeout_err), 64'd0);
        nreset = 1'b1;

        $display("[TB] single requester");
        addrArr[2] = 32'h1000_0400;
        lenArr[2]  = 9'd256;
        req_rnw    = 4'b0000;
        applyStimulus(4'b0100, 1, 10, win);
        checkOutput("single_ptr", 64'(expectWinner(4'b1111, modelPtr)), 64'd3);

        $display("[TB] fairness");
        modelPtr = 3;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < NREQ; i++) lenArr[i] = 9'd8;
            applyStimulus(4'b1111, 0, 4, win);
            checkOutput("fair_order", 64'(win), 64'((r + 3) % NREQ));
        end

        $display("[TB] zero length");
        lenArr[1] = '0;
        applyStimulus(4'b0010, 0, 0, win);

        $display("[TB] stability");
        addrArr[0] = 32'h100;
        lenArr[0]  = 9'd4;
        applyStimulus(4'b0001, 4, 2, win);

        $display("[TB] randomized");
        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                addrArr[i] = $urandom;
                lenArr[i]  = ($urandom_range(0, 3) == 0) ? '0 : LEN_W'($urandom_range(1, 256));
            end
            req_rnw = NREQ'($urandom);
            applyStimulus(NREQ'($urandom_range(0, 15)), $urandom_range(0, 3),
                          $urandom_range(0, 8), win);
        end

        $display("[TB] done on watchdog expiry cycle");
        lenArr[2] = 9'd5;
        applyStimulus(4'b0100, 0, TIMEOUT - 1, win);
        checkOutput("late_done_err", 64'(timeout_err), 64'd0);

        $display("[TB] watchdog");
        lenArr[1] = 9'd7;
        req = 4'b0010;
        win = expectWinner(req, modelPtr);
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        for (int c = 0; c < TIMEOUT - 1; c++) tick();
        checkOutput("wd_before", 64'(timeout_err), 64'd0);
        checkOutput("wd_before_gnt", 64'(gnt), 64'(1) << win);
        tick();
        checkOutput("wd_err", 64'(timeout_err), 64'd1);
        tick();
        checkOutput("wd_reqdone", 64'(req_done), 64'(1) << win);
        checkOutput("wd_gnt", 64'(gnt), 64'd0);
        req = '0;
        modelPtr = (win + 1) % NREQ;
        axi_done = 1'b1;
        tick();
        axi_done = 1'b0;
        tick();
        checkOutput("wd_late_busy", 64'(busy), 64'd0);
        checkOutput("wd_late_done", 64'(req_done), 64'd0);
        checkOutput("wd_sticky", 64'(timeout_err), 64'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checkOutput("wd_clear", 64'(timeout_err), 64'd0);

        $display("[TB] async reset mid-wait");
        lenArr[0] = 9'd3;
        req = 4'b0001;
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        tick();
        tick();
        checkOutput("pre_rst_gnt", 64'(gnt), 64'd1);
        nreset = 1'b0;
        #1;
        checkOutput("arst_gnt", 64'(gnt), 64'd0);
        checkOutput("arst_mgo", 64'(m_go), 64'd0);
        checkOutput("arst_busy", 64'(busy), 64'd0);
        checkOutput("arst_done", 64'(req_done), 64'd0);
        req = '0;
        #3;
        nreset = 1'b1;
        modelPtr = 0;
        lenArr[1] = 9'd2;
        lenArr[3] = 9'd2;
        applyStimulus(4'b1010, 0, 1, win);
        checkOutput("arst_first", 64'(win), 64'd1);
        applyStimulus(4'b1000, 0, 1, win);
        checkOutput("arst_second", 64'(win), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
